// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs, segment-register
// enable/clear outputs and the statistics counters.
//   master : pipeline side, drives hazard inputs, receives En/Clr/counters
//   slave  : hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [1:0]       RegReadD;
    logic [4:0]       RdE;
    logic             MemToRegE;
    logic             JalD, JalrE;
    logic             BrValidE, BrTakenE, PredictedE;
    logic             DCacheMissM, DCacheReady;
    logic             CntClr;
    logic             EnF, EnD, EnE, EnM, EnW;
    logic             ClrD, ClrE, ClrM, ClrW;
    logic [CNT_W-1:0] BrCnt, MispCnt, StallCnt;

    modport master (
        output Rs1D, Rs2D, RegReadD, RdE, MemToRegE, JalD, JalrE,
               BrValidE, BrTakenE, PredictedE, DCacheMissM, DCacheReady, CntClr,
        input  EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW,
               BrCnt, MispCnt, StallCnt
    );

    modport slave (
        input  Rs1D, Rs2D, RegReadD, RdE, MemToRegE, JalD, JalrE,
               BrValidE, BrTakenE, PredictedE, DCacheMissM, DCacheReady, CntClr,
        output EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW,
               BrCnt, MispCnt, StallCnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32I pipeline.
// Drives En/Clr of the IF/ID/EX/MEM/WB segment registers to resolve
// D-cache miss freezes, EX-resolved mispredicts/JALR, load-use hazards and
// JAL redirects (that priority order), and keeps saturating statistics.
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset (flushes every segment register)
//   bus   : pipe_hazard_ctrl_if.slave, hazard inputs / En, Clr, counters
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             misp_br, misp, load_use;
    logic             en_f, en_d, en_e, en_m, en_w;
    logic             clr_d, clr_e, clr_m, clr_w;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign misp_br  = bus.BrValidE & (bus.BrTakenE ^ bus.PredictedE);
    assign misp     = misp_br | bus.JalrE;
    // x0 is never a real dependency, so a load to x0 never stalls.
    assign load_use = bus.MemToRegE & (bus.RdE != 5'd0) &
                      ((bus.RegReadD[1] & (bus.Rs1D == bus.RdE)) |
                       (bus.RegReadD[0] & (bus.Rs2D == bus.RdE)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state logic; a new miss while already waiting is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.DCacheMissM) state_d = MEMWAIT;
            MEMWAIT: if (bus.DCacheReady) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output logic. Reset forces En=1/Clr=1 so every segment register
    // flushes while rst_n is low.
    always_comb begin
        {en_f, en_d, en_e, en_m, en_w} = 5'b11111;
        {clr_d, clr_e, clr_m, clr_w}   = 4'b0000;
        if (!rst_n) begin
            {clr_d, clr_e, clr_m, clr_w} = 4'b1111;
        end else if (state_q == MEMWAIT || bus.DCacheMissM) begin
            // MEMWAIT holds the freeze through the cycle DCacheReady is high.
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
        end else if (misp) begin
            clr_d = 1'b1;
            clr_e = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID, push a bubble into EX.
            en_f  = 1'b0;
            en_d  = 1'b0;
            clr_e = 1'b1;
        end else if (bus.JalD) begin
            clr_d = 1'b1;
        end
    end

    assign bus.EnF  = en_f;
    assign bus.EnD  = en_d;
    assign bus.EnE  = en_e;
    assign bus.EnM  = en_m;
    assign bus.EnW  = en_w;
    assign bus.ClrD = clr_d;
    assign bus.ClrE = clr_e;
    assign bus.ClrM = clr_m;
    assign bus.ClrW = clr_w;

    // Statistics: saturating increments, clear wins over increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        return (inc && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    always_comb begin
        br_cnt_d    = '0;
        misp_cnt_d  = '0;
        stall_cnt_d = '0;
        if (!bus.CntClr) begin
            br_cnt_d    = sat_inc(br_cnt_q, bus.BrValidE & en_e);
            // Only the branch term counts; JALR redirects are excluded.
            misp_cnt_d  = sat_inc(misp_cnt_q, (state_q == RUN) &
                                  ~bus.DCacheMissM & misp_br);
            stall_cnt_d = sat_inc(stall_cnt_q, ~en_f);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            misp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            misp_cnt_q  <= misp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.BrCnt    = br_cnt_q;
    assign bus.MispCnt  = misp_cnt_q;
    assign bus.StallCnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the combinational
// priority logic, then hand-written miss, reset and saturation sequences.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;

    // Output bit order: {EnF,EnD,EnE,EnM,EnW,ClrD,ClrE,ClrM,ClrW}
    localparam logic [8:0] O_IDLE  = 9'b11111_0000;
    localparam logic [8:0] O_LU    = 9'b00111_0100;
    localparam logic [8:0] O_MISP  = 9'b11111_1100;
    localparam logic [8:0] O_JAL   = 9'b11111_1000;
    localparam logic [8:0] O_RST   = 9'b11111_1111;
    localparam logic [8:0] O_FRZ   = 9'b00000_0000;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic [1:0] rr;
        logic [4:0] rd;
        logic       mem, jald, jalr, brv, brt, pred;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    logic [8:0] outv;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    assign outv = {bus.EnF, bus.EnD, bus.EnE, bus.EnM, bus.EnW,
                   bus.ClrD, bus.ClrE, bus.ClrM, bus.ClrW};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.RegReadD = 2'b00; bus.RdE = 5'd0;
        bus.MemToRegE = 1'b0; bus.JalD = 1'b0; bus.JalrE = 1'b0;
        bus.BrValidE = 1'b0; bus.BrTakenE = 1'b0; bus.PredictedE = 1'b0;
        bus.DCacheMissM = 1'b0; bus.DCacheReady = 1'b0; bus.CntClr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] rr, input logic [4:0] rd, input logic mem,
                       input logic jald, input logic jalr, input logic brv,
                       input logic brt, input logic pred, input logic [8:0] exp);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rr = rr; v.rd = rd; v.mem = mem;
        v.jald = jald; v.jalr = jalr; v.brv = brv; v.brt = brt; v.pred = pred;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        //    name          rs1 rs2 rr     rd mem jal jr brv brt prd exp
        add("idle",         0,  0,  2'b00, 0, 0,  0,  0, 0,  0,  0,  O_IDLE);
        add("lu_rs1",       5,  0,  2'b10, 5, 1,  0,  0, 0,  0,  0,  O_LU);
        add("lu_rs2",       1,  5,  2'b01, 5, 1,  0,  0, 0,  0,  0,  O_LU);
        add("rs1_unused",   5,  6,  2'b01, 5, 1,  0,  0, 0,  0,  0,  O_IDLE);
        add("load_x0",      0,  0,  2'b11, 0, 1,  0,  0, 0,  0,  0,  O_IDLE);
        add("misp_over_lu", 5,  0,  2'b10, 5, 1,  0,  0, 1,  1,  0,  O_MISP);
        add("br_ok_lu",     5,  0,  2'b10, 5, 1,  0,  0, 1,  1,  1,  O_LU);
        add("misp_nt",      0,  0,  2'b00, 0, 0,  0,  0, 1,  0,  1,  O_MISP);
        add("jalr_jal",     0,  0,  2'b00, 0, 0,  1,  1, 0,  0,  0,  O_MISP);
        add("jal",          0,  0,  2'b00, 0, 0,  1,  0, 0,  0,  0,  O_JAL);
        add("lu_over_jal",  7,  0,  2'b10, 7, 1,  1,  0, 0,  0,  0,  O_LU);
        add("no_load",      5,  5,  2'b11, 5, 0,  0,  0, 0,  0,  0,  O_IDLE);

        // Reset state
        idle();
        #2;
        chk("reset_out", outv, O_RST);
        chk("reset_br", bus.BrCnt, 0);
        chk("reset_misp", bus.MispCnt, 0);
        chk("reset_stall", bus.StallCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Priority table; each vector is also clocked once into the counters.
        foreach (tbl[i]) begin
            bus.Rs1D = tbl[i].rs1; bus.Rs2D = tbl[i].rs2; bus.RegReadD = tbl[i].rr;
            bus.RdE = tbl[i].rd; bus.MemToRegE = tbl[i].mem; bus.JalD = tbl[i].jald;
            bus.JalrE = tbl[i].jalr; bus.BrValidE = tbl[i].brv;
            bus.BrTakenE = tbl[i].brt; bus.PredictedE = tbl[i].pred;
            #2;
            chk(tbl[i].name, outv, tbl[i].exp);
            step();
        end
        idle();
        #2;
        // Branches: misp_over_lu, br_ok_lu, misp_nt. Mispredicts: 2 (JALR excluded).
        // Stalls: lu_rs1, lu_rs2, br_ok_lu, lu_over_jal.
        chk("tbl_br", bus.BrCnt, 3);
        chk("tbl_misp", bus.MispCnt, 2);
        chk("tbl_stall", bus.StallCnt, 4);

        bus.CntClr = 1'b1;
        step();
        idle();
        #2;
        chk("clr_br", bus.BrCnt, 0);
        chk("clr_misp", bus.MispCnt, 0);
        chk("clr_stall", bus.StallCnt, 0);

        // Miss at t, ready at t+4: five frozen cycles.
        @(negedge clk);
        bus.DCacheMissM = 1'b1;
        #2 chk("miss_t0", outv, O_FRZ);
        step();
        bus.BrValidE = 1'b1;           // frozen branch must not count
        bus.BrTakenE = 1'b1;
        #2 chk("miss_t1", outv, O_FRZ);
        step();
        idle();
        #2 chk("miss_t2", outv, O_FRZ);
        step();
        #2 chk("miss_t3", outv, O_FRZ);
        step();
        bus.DCacheReady = 1'b1;
        #2 chk("miss_ready", outv, O_FRZ);
        step();
        idle();
        #2 chk("miss_after", outv, O_IDLE);
        chk("miss_stall", bus.StallCnt, 5);
        chk("miss_br", bus.BrCnt, 0);
        chk("miss_misp", bus.MispCnt, 0);

        // Reset while in MEMWAIT
        bus.DCacheMissM = 1'b1;
        step();
        idle();
        #2 chk("mw_frozen", outv, O_FRZ);
        rst_n = 1'b0;
        #1 chk("mw_rst_out", outv, O_RST);
        chk("mw_rst_stall", bus.StallCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2 chk("mw_rel_out", outv, O_IDLE);
        step();
        #2 chk("mw_run", outv, O_IDLE);

        // Saturation
        bus.BrValidE = 1'b1;
        repeat (15) step();
        #2 chk("sat_15", bus.BrCnt, 15);
        repeat (2) step();
        #2 chk("sat_hold", bus.BrCnt, 15);
        chk("sat_misp", bus.MispCnt, 0);
        bus.CntClr = 1'b1;
        step();
        bus.CntClr = 1'b0;
        #2 chk("clr_vs_inc", bus.BrCnt, 0);
        step();
        idle();
        #2 chk("inc_after_clr", bus.BrCnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
